// File: rtl/relu_seq_if.sv
// Handshake bundle between the relu_seq sequencer and the accumulator / ReLU control path.
// The sequencer takes the slave side; the surrounding logic (or a bench) takes the master side.
interface relu_seq_if #(
    parameter int LANEW = 4,
    parameter int SIZEW = 16
);
    logic             req;
    logic [SIZEW-1:0] out_size;
    logic             relu_en;
    logic             grp_ready;
    logic             stall;
    logic             grp_ack;
    logic             ctrl_start;
    logic             ctrl_valid;
    logic             ctrl_stop;
    logic [LANEW-1:0] lane_sel;
    logic [SIZEW-1:0] waddr;
    logic             relu_bypass;
    logic             busy;
    logic             done;

    modport slave (
        input  req, out_size, relu_en, grp_ready, stall,
        output grp_ack, ctrl_start, ctrl_valid, ctrl_stop, lane_sel, waddr,
               relu_bypass, busy, done
    );

    modport master (
        output req, out_size, relu_en, grp_ready, stall,
        input  grp_ack, ctrl_start, ctrl_valid, ctrl_stop, lane_sel, waddr,
               relu_bypass, busy, done
    );
endinterface

// File: rtl/relu_seq.sv
// Output-stage sequencer: serializes completed N_PE-lane accumulator groups into a
// start/valid/stop element stream for the ReLU pipeline, then drains and signals done.
module relu_seq #(
    parameter int N_PE   = 16,
    parameter int LANEW  = $clog2(N_PE),
    parameter int D_RELU = 3,
    parameter int SIZEW  = 16
) (
    input  logic      clk,
    input  logic      xrst,
    relu_seq_if.slave bus
);
    localparam int               DRW        = $clog2(D_RELU + 1);
    localparam logic [DRW-1:0]   DRAIN_LAST = DRW'(D_RELU);
    localparam logic [LANEW-1:0] LANE_LAST  = LANEW'(N_PE - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t           r_state, w_state_nx;
    logic [SIZEW-1:0] r_size, w_size_nx;
    logic [SIZEW-1:0] r_elem, w_elem_nx;
    logic [LANEW-1:0] r_lane, w_lane_nx;
    logic [DRW-1:0]   r_drain, w_drain_nx;
    logic             r_bypass, w_bypass_nx;

    logic             w_last, w_grp_end;

    logic             w_start_p0, w_vld_p0, w_stop_p0, w_ack_p0, w_busy_p0, w_done_p0;
    logic [LANEW-1:0] w_lane_p0;
    logic [SIZEW-1:0] w_waddr_p0;

    logic             r_start_p1, r_vld_p1, r_stop_p1, r_ack_p1, r_busy_p1, r_done_p1;
    logic [LANEW-1:0] r_lane_p1;
    logic [SIZEW-1:0] r_waddr_p1;

    assign w_last    = (r_elem == r_size - SIZEW'(1));
    assign w_grp_end = w_last || (r_lane == LANE_LAST);

    always_comb begin
        w_state_nx  = r_state;
        w_size_nx   = r_size;
        w_elem_nx   = r_elem;
        w_lane_nx   = r_lane;
        w_drain_nx  = r_drain;
        w_bypass_nx = r_bypass;
        w_start_p0  = 1'b0;
        w_vld_p0    = 1'b0;
        w_stop_p0   = 1'b0;
        w_ack_p0    = 1'b0;
        w_done_p0   = 1'b0;
        w_busy_p0   = (r_state != S_IDLE);
        w_lane_p0   = r_lane_p1;
        w_waddr_p0  = r_waddr_p1;

        unique case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_busy_p0 = 1'b1;
                    if (bus.out_size != '0) begin
                        w_state_nx  = S_WAIT;
                        w_size_nx   = bus.out_size;
                        w_bypass_nx = !bus.relu_en;
                        w_elem_nx   = '0;
                        w_lane_nx   = '0;
                        w_start_p0  = 1'b1;
                    end else begin
                        w_state_nx = S_FIN;
                    end
                end
            end
            S_WAIT: begin
                if (bus.grp_ready) w_state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                if (!bus.stall) begin
                    w_vld_p0   = 1'b1;
                    w_lane_p0  = r_lane;
                    w_waddr_p0 = r_elem;
                    w_elem_nx  = r_elem + SIZEW'(1);
                    w_lane_nx  = r_lane + LANEW'(1);
                    // A partial final group ends early, so the lane is cleared explicitly.
                    if (w_grp_end) begin
                        w_ack_p0   = 1'b1;
                        w_stop_p0  = w_last;
                        w_lane_nx  = '0;
                        w_drain_nx = '0;
                        w_state_nx = w_last ? S_DRAIN : S_WAIT;
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_LAST) w_state_nx = S_FIN;
                else                       w_drain_nx = r_drain + DRW'(1);
            end
            S_FIN: begin
                w_done_p0  = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // ---- p0 -> p1: state update and registered outputs ----
    always_ff @(posedge clk) begin
        if (xrst) begin
            r_state    <= S_IDLE;
            r_size     <= '0;
            r_elem     <= '0;
            r_lane     <= '0;
            r_drain    <= '0;
            r_bypass   <= 1'b0;
            r_start_p1 <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_stop_p1  <= 1'b0;
            r_ack_p1   <= 1'b0;
            r_busy_p1  <= 1'b0;
            r_done_p1  <= 1'b0;
            r_lane_p1  <= '0;
            r_waddr_p1 <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_size     <= w_size_nx;
            r_elem     <= w_elem_nx;
            r_lane     <= w_lane_nx;
            r_drain    <= w_drain_nx;
            r_bypass   <= w_bypass_nx;
            r_start_p1 <= w_start_p0;
            r_vld_p1   <= w_vld_p0;
            r_stop_p1  <= w_stop_p0;
            r_ack_p1   <= w_ack_p0;
            r_busy_p1  <= w_busy_p0;
            r_done_p1  <= w_done_p0;
            r_lane_p1  <= w_lane_p0;
            r_waddr_p1 <= w_waddr_p0;
        end
    end

    assign bus.ctrl_start  = r_start_p1;
    assign bus.ctrl_valid  = r_vld_p1;
    assign bus.ctrl_stop   = r_stop_p1;
    assign bus.grp_ack     = r_ack_p1;
    assign bus.lane_sel    = r_lane_p1;
    assign bus.waddr       = r_waddr_p1;
    assign bus.relu_bypass = r_bypass;
    assign bus.busy        = r_busy_p1;
    assign bus.done        = r_done_p1;
endmodule

// File: tb/tb_relu_seq.sv
// Directed bench for relu_seq: layer sizes, partial groups, stalls, empty layers,
// ignored requests, mid-layer reset and ReLU bypass latching.
module tb_relu_seq;
    localparam int N_PE   = 16;
    localparam int LANEW  = $clog2(N_PE);
    localparam int D_RELU = 3;
    localparam int SIZEW  = 16;

    logic clk = 1'b0;
    logic xrst;
    always #5 clk = ~clk;

    relu_seq_if #(.LANEW(LANEW), .SIZEW(SIZEW)) bus ();

    relu_seq #(.N_PE(N_PE), .LANEW(LANEW), .D_RELU(D_RELU), .SIZEW(SIZEW)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    int n_chk;
    int n_fail;

    int cyc = 0;
    int req_cyc;
    int n_start, n_done, start_cyc, first_vcyc, last_vcyc, done_cyc;
    bit done_busy;
    logic [SIZEW-1:0] v_addr[$];
    logic [LANEW-1:0] v_lane[$];
    logic [SIZEW-1:0] ack_addr[$];
    logic [SIZEW-1:0] stop_addr[$];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (bus.ctrl_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (bus.ctrl_valid) begin
            if (v_addr.size() == 0) first_vcyc = cyc;
            v_addr.push_back(bus.waddr);
            v_lane.push_back(bus.lane_sel);
            last_vcyc = cyc;
        end
        if (bus.grp_ack)   ack_addr.push_back(bus.ctrl_valid ? bus.waddr : '1);
        if (bus.ctrl_stop) stop_addr.push_back(bus.ctrl_valid ? bus.waddr : '1);
        if (bus.done) begin
            n_done++;
            done_cyc  = cyc;
            done_busy = bus.busy;
        end
    end

    task automatic clear_mon();
        n_start = 0; n_done = 0; start_cyc = -1; first_vcyc = -1; last_vcyc = -1;
        done_cyc = -1; done_busy = 1'b0;
        v_addr.delete(); v_lane.delete(); ack_addr.delete(); stop_addr.delete();
    endtask

    task automatic do_req(input int size, input bit en);
        @(posedge clk); #1;
        bus.req = 1'b1; bus.out_size = SIZEW'(size); bus.relu_en = en;
        @(posedge clk);
        req_cyc = cyc;
        #1 bus.req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (n_done == 0) chk_eq({tag, "_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valids(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (v_addr.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (v_addr.size() < n) chk_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic chk_seq(input string tag, input int n);
        chk_eq({tag, "_nvalid"}, v_addr.size(), n);
        for (int i = 0; i < v_addr.size(); i++) begin
            chk_eq({tag, "_waddr"}, v_addr[i], i);
            chk_eq({tag, "_lane"}, v_lane[i], i % N_PE);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        clear_mon();
        xrst = 1'b1;
        bus.req = 1'b0; bus.out_size = '0; bus.relu_en = 1'b0;
        bus.grp_ready = 1'b0; bus.stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_valid", bus.ctrl_valid, 0);
        chk_eq("rst_start", bus.ctrl_start, 0);
        chk_eq("rst_ack", bus.grp_ack, 0);
        chk_eq("rst_busy", bus.busy, 0);
        chk_eq("rst_done", bus.done, 0);
        chk_eq("rst_waddr", bus.waddr, 0);
        chk_eq("rst_bypass", bus.relu_bypass, 0);
        xrst = 1'b0;
        bus.grp_ready = 1'b1;

        // 32 elements: two full groups with one bubble between them
        clear_mon();
        do_req(32, 1'b1);
        wait_done("t1", 300);
        chk_eq("t1_nstart", n_start, 1);
        chk_eq("t1_start_lat", start_cyc - req_cyc, 1);
        chk_eq("t1_first_valid_lat", first_vcyc - req_cyc, 3);
        chk_seq("t1", 32);
        chk_eq("t1_span", last_vcyc - first_vcyc, 32);
        chk_eq("t1_nack", ack_addr.size(), 2);
        if (ack_addr.size() == 2) begin
            chk_eq("t1_ack0", ack_addr[0], 15);
            chk_eq("t1_ack1", ack_addr[1], 31);
        end
        chk_eq("t1_nstop", stop_addr.size(), 1);
        if (stop_addr.size() == 1) chk_eq("t1_stop", stop_addr[0], 31);
        chk_eq("t1_done_lat", done_cyc - last_vcyc, D_RELU + 2);
        chk_eq("t1_ndone", n_done, 1);
        chk_eq("t1_busy_at_done", done_busy, 1);
        chk_eq("t1_busy_after", bus.busy, 0);
        chk_eq("t1_bypass", bus.relu_bypass, 0);

        // 20 elements: partial second group of lanes 0..3
        clear_mon();
        do_req(20, 1'b1);
        wait_done("t2", 300);
        chk_seq("t2", 20);
        chk_eq("t2_nack", ack_addr.size(), 2);
        if (ack_addr.size() == 2) begin
            chk_eq("t2_ack0", ack_addr[0], 15);
            chk_eq("t2_ack1", ack_addr[1], 19);
        end
        chk_eq("t2_nstop", stop_addr.size(), 1);
        if (stop_addr.size() == 1) chk_eq("t2_stop", stop_addr[0], 19);
        chk_eq("t2_done_lat", done_cyc - last_vcyc, D_RELU + 2);

        // 16 elements with a three-cycle stall after element 5 has been issued
        clear_mon();
        do_req(16, 1'b1);
        wait_valids("t3", 5, 50);
        bus.stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_eq("t3_stall_valid", bus.ctrl_valid, 0);
        chk_eq("t3_stall_waddr_hold", bus.waddr, 5);
        chk_eq("t3_stall_lane_hold", bus.lane_sel, 5);
        @(posedge clk);
        @(posedge clk); #1;
        bus.stall = 1'b0;
        wait_done("t3", 300);
        chk_seq("t3", 16);
        chk_eq("t3_span", last_vcyc - first_vcyc, 15 + 3);
        chk_eq("t3_nack", ack_addr.size(), 1);
        if (ack_addr.size() == 1) chk_eq("t3_ack", ack_addr[0], 15);
        chk_eq("t3_nstop", stop_addr.size(), 1);

        // empty layer
        clear_mon();
        do_req(0, 1'b1);
        wait_done("t4", 20);
        chk_eq("t4_done_lat", done_cyc - req_cyc, 2);
        chk_eq("t4_busy_at_done", done_busy, 1);
        chk_eq("t4_nstart", n_start, 0);
        chk_eq("t4_nvalid", v_addr.size(), 0);
        chk_eq("t4_nstop", stop_addr.size(), 0);
        chk_eq("t4_nack", ack_addr.size(), 0);

        // second req while busy is ignored (size and mode)
        clear_mon();
        do_req(8, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        bus.req = 1'b1; bus.out_size = SIZEW'(3); bus.relu_en = 1'b0;
        @(posedge clk); #1;
        bus.req = 1'b0;
        wait_done("t4b", 200);
        chk_seq("t4b", 8);
        chk_eq("t4b_nstart", n_start, 1);
        chk_eq("t4b_nstop", stop_addr.size(), 1);
        if (stop_addr.size() == 1) chk_eq("t4b_stop", stop_addr[0], 7);
        chk_eq("t4b_bypass", bus.relu_bypass, 0);

        // reset in the middle of a 16-element bypass layer
        clear_mon();
        do_req(16, 1'b0);
        wait_valids("t5", 7, 50);
        chk_eq("t5_bypass_on", bus.relu_bypass, 1);
        chk_eq("t5_busy_mid", bus.busy, 1);
        xrst = 1'b1;
        @(posedge clk); #1;
        xrst = 1'b0;
        chk_eq("t5_rst_valid", bus.ctrl_valid, 0);
        chk_eq("t5_rst_waddr", bus.waddr, 0);
        chk_eq("t5_rst_lane", bus.lane_sel, 0);
        chk_eq("t5_rst_busy", bus.busy, 0);
        chk_eq("t5_rst_bypass", bus.relu_bypass, 0);
        chk_eq("t5_rst_ack", bus.grp_ack, 0);
        repeat (15) @(posedge clk);
        #1;
        chk_eq("t5_no_done", n_done, 0);
        chk_eq("t5_no_ack", ack_addr.size(), 0);
        chk_eq("t5_no_stop", stop_addr.size(), 0);
        chk_eq("t5_idle_busy", bus.busy, 0);

        clear_mon();
        do_req(4, 1'b1);
        wait_done("t5b", 100);
        chk_seq("t5b", 4);
        chk_eq("t5b_nack", ack_addr.size(), 1);
        if (ack_addr.size() == 1) chk_eq("t5b_ack", ack_addr[0], 3);
        chk_eq("t5b_nstop", stop_addr.size(), 1);
        if (stop_addr.size() == 1) chk_eq("t5b_stop", stop_addr[0], 3);
        chk_eq("t5b_ndone", n_done, 1);

        // bypass persists past done until the next accepted req with relu_en=1
        clear_mon();
        do_req(2, 1'b0);
        wait_done("t6", 100);
        chk_seq("t6", 2);
        repeat (4) @(posedge clk);
        #1;
        chk_eq("t6_bypass_hold", bus.relu_bypass, 1);
        clear_mon();
        do_req(1, 1'b1);
        #1;
        chk_eq("t6_bypass_clear", bus.relu_bypass, 0);
        wait_done("t6b", 100);
        chk_seq("t6b", 1);
        chk_eq("t6b_nack", ack_addr.size(), 1);
        if (ack_addr.size() == 1) chk_eq("t6b_ack", ack_addr[0], 0);
        chk_eq("t6b_nstop", stop_addr.size(), 1);
        if (stop_addr.size() == 1) chk_eq("t6b_stop", stop_addr[0], 0);
        chk_eq("t6b_done_lat", done_cyc - last_vcyc, D_RELU + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
